// File: rtl/spi_irq_collector.sv
// ============================================================================
// Module   : spi_irq_collector
// Purpose  : Turns 1-cycle SPI irq pulses into a CPU level interrupt with
//            saturating event coalescing and a post-ack holdoff window.
//            Optional unacked-timeout flag built when SPI_IRQ_TIMEOUT_EN is
//            defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_irq_collector #(
  parameter int CNT_W   = 8,
  parameter int HOLDOFF = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_irq_in,
  input  logic             i_ack,
  output logic             o_irq_level,
  output logic [CNT_W-1:0] o_pending_cnt,
  output logic             o_overflow,
  output logic             o_holdoff,
  output logic             o_timeout
);

  localparam int               HT_W        = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
  localparam logic [HT_W-1:0]  C_HOLD_INIT = HT_W'(HOLDOFF - 1);

  if (HOLDOFF < 1) begin : g_bad_holdoff
    $error("spi_irq_collector: HOLDOFF must be >= 1");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("spi_irq_collector: TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t           r_state;
  logic [HT_W-1:0]  r_hold_tmr;
  logic             r_irq_level;
  logic [CNT_W-1:0] r_pending_cnt;
  logic             r_overflow;
  logic             r_holdoff;

  logic             w_cnt_at_max;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_at_max = (r_pending_cnt == C_CNT_MAX);
  assign w_cnt_inc    = w_cnt_at_max ? r_pending_cnt : r_pending_cnt + C_CNT_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_hold_tmr    <= '0;
      r_irq_level   <= 1'b0;
      r_pending_cnt <= '0;
      r_overflow    <= 1'b0;
      r_holdoff     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_irq_in) begin
            r_pending_cnt <= C_CNT_ONE;
            r_irq_level   <= 1'b1;
            r_state       <= S_PENDING;
          end
        end

        S_PENDING: begin
          if (i_ack) begin
            // A pulse coincident with the ack seeds the next interrupt.
            r_pending_cnt <= i_irq_in ? C_CNT_ONE : '0;
            r_irq_level   <= 1'b0;
            r_overflow    <= 1'b0;
            r_holdoff     <= 1'b1;
            r_hold_tmr    <= C_HOLD_INIT;
            r_state       <= S_HOLD;
          end else if (i_irq_in) begin
            r_pending_cnt <= w_cnt_inc;
            if (w_cnt_at_max) r_overflow <= 1'b1;
          end
        end

        S_HOLD: begin
          if (i_irq_in) begin
            r_pending_cnt <= w_cnt_inc;
            if (w_cnt_at_max) r_overflow <= 1'b1;
          end
          if (r_hold_tmr == '0) begin
            r_holdoff <= 1'b0;
            // Count is non-zero after this edge if it already was or a pulse lands now.
            if (i_irq_in || (r_pending_cnt != '0)) begin
              r_irq_level <= 1'b1;
              r_state     <= S_PENDING;
            end else begin
              r_state     <= S_IDLE;
            end
          end else begin
            r_hold_tmr <= r_hold_tmr - HT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_irq_level   = r_irq_level;
  assign o_pending_cnt = r_pending_cnt;
  assign o_overflow    = r_overflow;
  assign o_holdoff     = r_holdoff;

`ifdef SPI_IRQ_TIMEOUT_EN
  localparam int              TO_W   = $clog2(TIMEOUT);
  localparam logic [TO_W-1:0] C_TO_L = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  // Counter is held at zero outside PENDING, so it starts fresh on every entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if (r_state == S_PENDING) begin
      if (i_ack) begin
        r_timeout <= 1'b0;
      end else if (r_to_cnt == C_TO_L) begin
        r_timeout <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_irq_collector.sv
// ============================================================================
// Module   : tb_spi_irq_collector
// Purpose  : Directed self-checking bench; one CNT_W=8 and one CNT_W=2
//            instance share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_irq_collector;

`ifdef SPI_IRQ_TIMEOUT_EN
  localparam logic C_TO_EN = 1'b1;
`else
  localparam logic C_TO_EN = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       irq   = 1'b0;
  logic       ack   = 1'b0;

  logic       a_lvl, a_ovf, a_hold, a_to;
  logic [7:0] a_cnt;
  logic       b_lvl, b_ovf, b_hold, b_to;
  logic [1:0] b_cnt;

  int checks = 0;
  int errors = 0;

  spi_irq_collector #(.CNT_W(8), .HOLDOFF(16), .TIMEOUT(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_irq_in(irq), .i_ack(ack),
    .o_irq_level(a_lvl), .o_pending_cnt(a_cnt), .o_overflow(a_ovf),
    .o_holdoff(a_hold), .o_timeout(a_to)
  );

  spi_irq_collector #(.CNT_W(2), .HOLDOFF(16), .TIMEOUT(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_irq_in(irq), .i_ack(ack),
    .o_irq_level(b_lvl), .o_pending_cnt(b_cnt), .o_overflow(b_ovf),
    .o_holdoff(b_hold), .o_timeout(b_to)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_lvl", a_lvl, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_hold", a_hold, 0);
    chk("rst_to", a_to, 0);
    rst_n = 1'b1;
    tick();

    // Basic assert, coalesce, ack, holdoff
    irq = 1'b1; tick(); irq = 1'b0;
    chk("first_lvl", a_lvl, 1);
    chk("first_cnt", a_cnt, 1);
    irq = 1'b1; tick(3); irq = 1'b0;
    chk("coal_cnt", a_cnt, 4);
    chk("coal_lvl", a_lvl, 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("ack_lvl", a_lvl, 0);
    chk("ack_cnt", a_cnt, 0);
    chk("ack_hold", a_hold, 1);
    tick(15);
    chk("hold15_hold", a_hold, 1);
    chk("hold15_lvl", a_lvl, 0);
    tick();
    chk("hold16_hold", a_hold, 0);
    chk("hold16_lvl", a_lvl, 0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("idle_ack_lvl", a_lvl, 0);
    chk("idle_ack_cnt", a_cnt, 0);
    chk("idle_ack_hold", a_hold, 0);

    // Saturation on the narrow instance
    irq = 1'b1; tick(5); irq = 1'b0;
    chk("sat_b_cnt", b_cnt, 3);
    chk("sat_b_ovf", b_ovf, 1);
    chk("sat_a_cnt", a_cnt, 5);
    chk("sat_a_ovf", a_ovf, 0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("sat_ack_b_ovf", b_ovf, 0);
    chk("sat_ack_b_cnt", b_cnt, 0);
    tick(16);
    chk("sat_idle_lvl", a_lvl, 0);
    chk("sat_idle_hold", a_hold, 0);

    // Ack coincident with irq
    irq = 1'b1; tick(); irq = 1'b0;
    irq = 1'b1; ack = 1'b1; tick(); irq = 1'b0; ack = 1'b0;
    chk("coin_cnt", a_cnt, 1);
    chk("coin_lvl", a_lvl, 0);
    chk("coin_hold", a_hold, 1);
    tick(15);
    chk("coin15_lvl", a_lvl, 0);
    tick();
    chk("coin16_lvl", a_lvl, 1);
    chk("coin16_hold", a_hold, 0);
    chk("coin16_cnt", a_cnt, 1);

    // irq and ack during HOLD
    ack = 1'b1; tick(); ack = 1'b0;
    chk("h_ack_cnt", a_cnt, 0);
    tick(2);
    irq = 1'b1; tick(); irq = 1'b0;
    chk("h_irq_cnt", a_cnt, 1);
    chk("h_irq_lvl", a_lvl, 0);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("h_ack2_hold", a_hold, 1);
    chk("h_ack2_cnt", a_cnt, 1);
    tick(11);
    chk("h15_lvl", a_lvl, 0);
    chk("h15_hold", a_hold, 1);
    tick();
    chk("h16_lvl", a_lvl, 1);
    chk("h16_hold", a_hold, 0);
    chk("h16_cnt", a_cnt, 1);

    // Event in the final holdoff cycle
    ack = 1'b1; tick(); ack = 1'b0;
    tick(15);
    chk("last_pre_lvl", a_lvl, 0);
    irq = 1'b1; tick(); irq = 1'b0;
    chk("last_lvl", a_lvl, 1);
    chk("last_cnt", a_cnt, 1);
    chk("last_hold", a_hold, 0);

    // Unacked timeout
    tick(7);
    chk("to7", a_to, 0);
    tick();
    chk("to8", a_to, C_TO_EN);
    chk("to8_lvl", a_lvl, 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("to_ack", a_to, 0);
    chk("to_ack_lvl", a_lvl, 0);

    // Asynchronous reset mid-PENDING
    tick(16);
    irq = 1'b1; tick(2); irq = 1'b0;
    chk("pre_rst_cnt", a_cnt, 2);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_lvl", a_lvl, 0);
    chk("arst_cnt", a_cnt, 0);
    chk("arst_ovf", a_ovf, 0);
    chk("arst_hold", a_hold, 0);
    chk("arst_b_cnt", b_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_lvl", a_lvl, 0);
    chk("rel_cnt", a_cnt, 0);
    irq = 1'b1; tick(); irq = 1'b0;
    chk("rel_irq_lvl", a_lvl, 1);
    chk("rel_irq_cnt", a_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
